// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings for the RISC-V load/store widths
//   - FSM state type for the Wishbone master
//   - helpers: access legality check, store byte-lane select, store data replication
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } lsu_state_t;

   // 1 when the access is misaligned for its width or funct3 is not a load/store width.
   function automatic logic lsu_access_err(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic err;
      case (funct3)
         F3_B, F3_BU: err = 1'b0;
         F3_H, F3_HU: err = addr_lo[0];
         F3_W:        err = (addr_lo != 2'b00);
         default:     err = 1'b1;
      endcase
      return err;
   endfunction

   function automatic logic [3:0] lsu_store_sel(input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
      logic [3:0] sel;
      case (funct3)
         F3_B, F3_BU: sel = 4'b0001 << addr_lo;
         F3_H, F3_HU: sel = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:     sel = 4'b1111;
      endcase
      return sel;
   endfunction

   // Replicate the LSB-aligned store data across every lane it may land in.
   function automatic logic [31:0] lsu_store_data(input logic [2:0]  funct3,
                                                  input logic [31:0] wr_data);
      logic [31:0] data;
      case (funct3)
         F3_B, F3_BU: data = {4{wr_data[7:0]}};
         F3_H, F3_HU: data = {2{wr_data[15:0]}};
         default:     data = wr_data;
      endcase
      return data;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load data formatting.
//   addr_lo_i  byte offset of the load within the word
//   funct3_i   load width/signedness
//   rd_data_i  raw word from the bus
//   data_o     selected lane, sign- or zero-extended (word passes through)
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] rd_data_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rd_data_i[7:0];
      case (addr_lo_i)
         2'd0:    byte_lane = rd_data_i[7:0];
         2'd1:    byte_lane = rd_data_i[15:8];
         2'd2:    byte_lane = rd_data_i[23:16];
         default: byte_lane = rd_data_i[31:24];
      endcase
      half_lane = addr_lo_i[1] ? rd_data_i[31:16] : rd_data_i[15:0];

      case (funct3_i)
         F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
         F3_BU:   data_o = {24'h0, byte_lane};
         F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
         F3_HU:   data_o = {16'h0, half_lane};
         F3_W:    data_o = rd_data_i;
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_wb_master.sv
// lsu_wb_master: memory-stage load/store unit driving a pipelined Wishbone master.
//   Request side : req_valid/req_ready handshake, req_wr, req_funct3, req_addr, req_wr_data,
//                  flush cancels an in-flight operation.
//   Response side: rsp_valid single-cycle pulse, rsp_rd_data formatted load data, rsp_err.
//   Bus side     : wb_cyc, wb_stb, wb_wr_en, wb_addr (word aligned), wb_wr_data, wb_wr_sel,
//                  wb_ack, wb_stall, wb_rd_data.
//   Optional     : define LSU_ACK_TIMEOUT_EN to build an ack watchdog that ends a transaction
//                  with rsp_err after TIMEOUT_CYCLES cycles in REQ/WAIT.
module lsu_wb_master
   import lsu_pkg::*;
#(
   parameter  int unsigned MEMORY_BYTES   = 1024,
   parameter  int unsigned TIMEOUT_CYCLES = 16,
   localparam int unsigned ADDR_WIDTH     = $clog2(MEMORY_BYTES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wr_data,
   input  logic                  flush,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rd_data,
   output logic                  rsp_err,
   output logic                  wb_cyc,
   output logic                  wb_stb,
   output logic                  wb_wr_en,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   output logic [31:0]           wb_wr_data,
   output logic [3:0]            wb_wr_sel,
   input  logic                  wb_ack,
   input  logic                  wb_stall,
   input  logic [31:0]           wb_rd_data
);

   lsu_state_t            state_q, state_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            addr_lo_q, addr_lo_d;
   logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
   logic [31:0]           wb_wr_data_q, wb_wr_data_d;
   logic [3:0]            wb_wr_sel_q, wb_wr_sel_d;
   logic                  wb_wr_en_q, wb_wr_en_d;
   logic                  wb_cyc_q, wb_cyc_d;
   logic                  wb_stb_q, wb_stb_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [31:0]           rsp_rd_data_q, rsp_rd_data_d;
   logic [31:0]           load_data;
   logic                  complete, abort, timeout_hit;

   assign req_ready = rst_n && (state_q == IDLE) && !flush;

   lsu_load_align u_load_align (
      .addr_lo_i (addr_lo_q),
      .funct3_i  (funct3_q),
      .rd_data_i (wb_rd_data),
      .data_o    (load_data)
   );

`ifdef LSU_ACK_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

   // Counter is 0 in the first REQ cycle, so it reads N-1 in the N-th busy cycle.
   always_comb begin
      tmo_cnt_d = (state_q == IDLE) ? '0 : tmo_cnt_q + TmoW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign timeout_hit = (state_q != IDLE) && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      funct3_d      = funct3_q;
      addr_lo_d     = addr_lo_q;
      wb_addr_d     = wb_addr_q;
      wb_wr_data_d  = wb_wr_data_q;
      wb_wr_sel_d   = wb_wr_sel_q;
      wb_wr_en_d    = wb_wr_en_q;
      wb_cyc_d      = wb_cyc_q;
      wb_stb_d      = wb_stb_q;
      rsp_valid_d   = 1'b0;
      rsp_err_d     = 1'b0;
      rsp_rd_data_d = 32'h0;
      complete      = 1'b0;
      abort         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               if (lsu_access_err(req_funct3, req_addr[1:0])) begin
                  // Rejected without touching the bus.
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d      = REQ;
                  funct3_d     = req_funct3;
                  addr_lo_d    = req_addr[1:0];
                  wb_addr_d    = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  wb_wr_en_d   = req_wr;
                  wb_wr_sel_d  = req_wr ? lsu_store_sel(req_funct3, req_addr[1:0]) : 4'b0000;
                  wb_wr_data_d = req_wr ? lsu_store_data(req_funct3, req_wr_data) : 32'h0;
                  wb_cyc_d     = 1'b1;
                  wb_stb_d     = 1'b1;
               end
            end
         end
         REQ: begin
            if (flush) begin
               abort = 1'b1;
            end else if (!wb_stall) begin
               if (wb_ack) begin
                  complete = 1'b1;
               end else begin
                  state_d  = WAIT;
                  wb_stb_d = 1'b0;
               end
            end
         end
         WAIT: begin
            if (flush) begin
               abort = 1'b1;
            end else if (wb_ack) begin
               complete = 1'b1;
            end
         end
         default: abort = 1'b1;
      endcase

      if (timeout_hit && !abort && !complete) begin
         abort       = 1'b1;
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b1;
      end

      if (complete) begin
         rsp_valid_d   = 1'b1;
         rsp_rd_data_d = wb_wr_en_q ? 32'h0 : load_data;
      end

      if (abort || complete) begin
         state_d    = IDLE;
         wb_cyc_d   = 1'b0;
         wb_stb_d   = 1'b0;
         wb_wr_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         funct3_q      <= '0;
         addr_lo_q     <= '0;
         wb_addr_q     <= '0;
         wb_wr_data_q  <= '0;
         wb_wr_sel_q   <= '0;
         wb_wr_en_q    <= 1'b0;
         wb_cyc_q      <= 1'b0;
         wb_stb_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_rd_data_q <= '0;
      end else begin
         state_q       <= state_d;
         funct3_q      <= funct3_d;
         addr_lo_q     <= addr_lo_d;
         wb_addr_q     <= wb_addr_d;
         wb_wr_data_q  <= wb_wr_data_d;
         wb_wr_sel_q   <= wb_wr_sel_d;
         wb_wr_en_q    <= wb_wr_en_d;
         wb_cyc_q      <= wb_cyc_d;
         wb_stb_q      <= wb_stb_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_err_q     <= rsp_err_d;
         rsp_rd_data_q <= rsp_rd_data_d;
      end
   end

   assign wb_cyc      = wb_cyc_q;
   assign wb_stb      = wb_stb_q;
   assign wb_wr_en    = wb_wr_en_q;
   assign wb_addr     = wb_addr_q;
   assign wb_wr_data  = wb_wr_data_q;
   assign wb_wr_sel   = wb_wr_sel_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_rd_data = rsp_rd_data_q;

endmodule

// File: doc/lsu_wb_master.md
Name: lsu_wb_master

Overview:
- Load/store unit for stage 4 (memory). Sits between the execute/memory pipeline register and the data port of main memory.
- Accepts one load or store request at a time and drives a pipelined Wishbone master transaction.
- Generates byte-lane select and replicated write data for stores; aligns and sign/zero-extends read data for loads.
- Returns a single-cycle response, with a misalignment error flag, to writeback.

Parameters:
- MEMORY_BYTES, 1024, size of the addressed memory. ADDR_WIDTH = $clog2(MEMORY_BYTES) is a localparam.
- TIMEOUT_CYCLES, 16, ack watchdog limit. Used only when LSU_ACK_TIMEOUT_EN is defined.

Ports:
- clk  in  1  positive-edge system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  pipeline presents a memory operation
- req_ready  out  1  LSU can accept; high only in IDLE and not in reset
- req_wr  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  ADDR_WIDTH  byte address
- req_wr_data  in  32  store data, LSB-aligned
- flush  in  1  cancel the in-flight operation
- rsp_valid  out  1  one-cycle response pulse
- rsp_rd_data  out  32  formatted load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3 (or timeout, see Optional Feature)
- wb_cyc  out  1  bus cycle active
- wb_stb  out  1  request strobe
- wb_wr_en  out  1  write enable
- wb_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits forced to 0
- wb_wr_data  out  32  lane-replicated write data
- wb_wr_sel  out  4  byte-lane mask
- wb_ack  in  1  slave ack
- wb_stall  in  1  slave stall
- wb_rd_data  in  32  read data, valid only when wb_ack=1

Behaviour:
- Reset: while rst_n is low at a clock edge, the state goes to IDLE and every output register clears to 0. req_ready is 0 during reset.
- States: IDLE, REQ, WAIT.
- IDLE:
  - A request is accepted when req_valid && req_ready. All request fields are registered.
  - Error case: misaligned access (h/hu with addr[0]=1, w with addr[1:0]!=0) or funct3 in {011,110,111}. No bus activity occurs. Next cycle rsp_valid=1, rsp_err=1, rsp_rd_data=0. State stays IDLE.
  - Legal case: go to REQ. wb_cyc=1, wb_stb=1, wb_wr_en=req_wr.
- REQ:
  - wb_stb, wb_addr, wb_wr_data, wb_wr_sel and wb_wr_en hold stable while wb_stall=1.
  - When wb_stall=0: if wb_ack=1 in the same cycle, complete the operation; otherwise go to WAIT with wb_stb=0 and wb_cyc=1.
- WAIT:
  - wb_cyc=1, wb_stb=0. On wb_ack, complete the operation.
- Complete:
  - Capture wb_rd_data. Next cycle: rsp_valid=1 for one cycle, wb_cyc=0, state IDLE, req_ready=1.
  - Back-to-back accept in that same cycle is allowed.
- Latency with a zero-stall slave that acks one cycle after stb:
  - Accept at edge E0. stb high in cycle E0..E1. Ack in cycle E1..E2. rsp_valid in cycle E2..E3.
  - The next request can be accepted at E3.
- Store formatting:
  - b: data={4{d[7:0]}}, sel=4'b0001<<addr[1:0]
  - h: data={2{d[15:0]}}, sel=addr[1]?1100:0011
  - w: data=d, sel=1111
  - For all loads, sel=0000.
- Load formatting:
  - Select the byte lane from addr[1:0], or the halfword lane from addr[1].
  - b/h sign-extend; bu/hu zero-extend; w passes through unchanged.
- Flush:
  - In IDLE: the request is blocked (req_ready=0 while flush=1).
  - In REQ/WAIT: next cycle wb_cyc=0, wb_stb=0, state IDLE, no rsp_valid.
  - A late wb_ack in IDLE is ignored.
  - A store whose stb was already sampled is committed and cannot be revoked. The pipeline must not flush committed stores.
- Reset mid-transaction: same as flush, plus all registers clear. A late ack is ignored.
- Simultaneous flush and wb_ack: flush wins. No response is produced.

Optional Feature:
- Macro: LSU_ACK_TIMEOUT_EN.
- Defined:
  - A counter starts at entry to REQ and counts every cycle in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES without ack: drop wb_cyc/wb_stb, then issue rsp_valid=1, rsp_err=1, rsp_rd_data=0, and return to IDLE.
- Undefined:
  - No counter is built. The LSU waits indefinitely for wb_ack.

Decomposition:
- Package lsu_pkg contains:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum lsu_state_t {IDLE, REQ, WAIT}
  - functions for the store sel/data mask and the misalignment check
- Sub-module lsu_load_align: combinational extraction and extension of read data from addr[1:0] and funct3.

Test Plan:
- sw 0x12345678 @0x38: wb_addr=0x38, sel=1111, wb_wr_en=1. rsp_valid 3 cycles after accept, rsp_err=0.
- sb 0xAB @0x32 into a zeroed word, then lw @0x30: wb_wr_data=0xABABABAB, sel=0100. Load returns 0x00AB0000.
- Word @0x30 = 0x80FF7F01:
  - lb @0x33 → 0xFFFFFF80
  - lbu @0x33 → 0x00000080
  - lh @0x32 → 0xFFFF80FF
  - lhu @0x32 → 0x000080FF
- lh @0x31 and funct3=011: wb_cyc stays 0. rsp_valid next cycle with rsp_err=1, rsp_rd_data=0.
- wb_stall=1 for 3 cycles: wb_stb and wb_addr are held stable. rsp_valid arrives 2 cycles after stall release.
- flush in WAIT with wb_ack arriving the same cycle: wb_cyc=0 next cycle, no rsp_valid. A following lw completes normally.
